// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Opcode constants shared by fetch and decode, plus the fetch
//               FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-PC select: redirect > jump > pc+4.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc #(
    parameter int ADDR_W = 32
) (
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_target_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_index_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    // Redirect targets are forced to a word boundary.
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // Priority select; a jump keeps the region bits of the following instruction.
    always_comb begin
        next_pc_o = pc_plus4_i;
        if (redirect_valid_i) begin
            next_pc_o = redirect_target_i & c_ALIGN_MASK;
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_i[ADDR_W-1:28], jump_index_i, 2'b00};
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch front end. Holds the PC, fetches words over
//               a req/valid memory port, presents them with valid/ready,
//               resolves J locally and applies datapath redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic [31:0]       imemRdata,
    input  logic              imemValid,
    output logic              instrValid,
    input  logic              instrReady,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pcPlus4,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectTarget
);

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_jump;

    // pc stays at the held instruction's address while in HOLD, so this is stable there.
    assign w_pc_plus4 = pc_q + c_PC_STEP;
    assign w_jump     = (instr_q[31:26] == OP_J);

    fetch_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .redirect_valid_i  (redirectValid),
        .redirect_target_i (redirectTarget),
        .jump_i            (w_jump),
        .jump_index_i      (instr_q[25:0]),
        .pc_plus4_i        (w_pc_plus4),
        .next_pc_o         (w_next_pc)
    );

    // State, PC and instruction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic; a redirect overrides the handshake and kills held or in-flight data.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirectValid) begin
                    // Without a response this cycle, one is still outstanding and must be dropped.
                    state_d = imemValid ? ST_REQ : ST_DRAIN;
                end else if (imemValid) begin
                    instr_d = imemRdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirectValid) begin
                    state_d = ST_REQ;
                end else if (instrReady) begin
                    pc_d    = w_next_pc;
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imemValid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (redirectValid) begin
            pc_d = w_next_pc;
        end
    end

    assign imemReq    = (state_q == ST_REQ);
    assign imemAddr   = pc_q;
    assign instrValid = (state_q == ST_HOLD);
    assign instr      = instr_q;
    assign opcode     = instr_q[31:26];
    assign funct      = instr_q[5:0];
    assign pcPlus4    = w_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a scoreboard of
//               expected presented instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemValid;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pcPlus4;
    logic        redirectValid;
    logic [31:0] redirectTarget;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb[$];

    instr_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemRdata      (imemRdata),
        .imemValid      (imemValid),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .instr          (instr),
        .opcode         (opcode),
        .funct          (funct),
        .pcPlus4        (pcPlus4),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input string nm);
        for (int i = 0; i < 20; i++) begin
            if (imemReq) return;
            tick();
        end
        check({nm, "_req_timeout"}, 32'(imemReq), 32'd1);
    endtask

    // Answer the pending fetch after lat extra cycles; the word is expected to be presented.
    task automatic present(input logic [31:0] word, input logic [31:0] addr,
                           input int lat, input string nm);
        wait_req(nm);
        check({nm, "_addr"}, imemAddr, addr);
        repeat (lat) tick();
        imemValid = 1'b1;
        imemRdata = word;
        sb.push_back('{word, addr + 32'd4});
        tick();
        imemValid = 1'b0;
        check({nm, "_valid"}, 32'(instrValid), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] word, input logic [31:0] addr, input string nm);
        present(word, addr, 0, nm);
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic with_valid);
        redirectValid  = 1'b1;
        redirectTarget = tgt;
        imemValid      = with_valid;
        imemRdata      = 32'hDEAD_BEEF;
        tick();
        redirectValid  = 1'b0;
        imemValid      = 1'b0;
    endtask

    // Monitor: each new instrValid presentation is compared against the scoreboard head.
    initial begin : monitor
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (instrValid === 1'b1 && !prev_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: instrValid=1 word %h, required no output", instr);
                end else begin
                    e = sb.pop_front();
                    check("mon_instr", instr, e.word);
                    check("mon_opcode", 32'(opcode), 32'(e.word[31:26]));
                    check("mon_funct", 32'(funct), 32'(e.word[5:0]));
                    check("mon_pcplus4", pcPlus4, e.pc4);
                end
            end
            prev_v = (instrValid === 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset          = 1'b1;
        imemRdata      = '0;
        imemValid      = 1'b0;
        instrReady     = 1'b0;
        redirectValid  = 1'b0;
        redirectTarget = '0;
        repeat (3) tick();

        // Reset state
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_addr", imemAddr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pcplus4", pcPlus4, 32'h4);
        reset = 1'b0;
        tick();
        check("rel_req", 32'(imemReq), 32'd1);

        // First fetch with one-cycle memory latency, then stall the consumer
        present(32'h2008_0005, 32'h0, 1, "t1");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", instr, 32'h2008_0005);
            check("stall_req", 32'(imemReq), 32'd0);
            check("stall_valid", 32'(instrValid), 32'd1);
        end
        instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        check("accept_addr", imemAddr, 32'h4);
        check("accept_req", 32'(imemReq), 32'd1);

        // Jump resolution
        fetch(32'h0000_0000, 32'h4, "nop4");
        fetch(32'h0800_0010, 32'h8, "j8");
        check("jump_addr", imemAddr, 32'h40);

        // Redirect in the same cycle as the response: data dropped
        redirect(32'h20, 1'b1);
        check("rdv_addr", imemAddr, 32'h20);
        check("rdv_req", 32'(imemReq), 32'd1);
        check("rdv_valid", 32'(instrValid), 32'd0);

        // Redirect while holding, with a same-cycle (void) handshake
        present(32'h8C00_0000, 32'h20, 0, "hold20");
        instrReady = 1'b1;
        redirect(32'h20, 1'b0);
        instrReady = 1'b0;
        check("rdh_addr", imemAddr, 32'h20);
        check("rdh_valid", 32'(instrValid), 32'd0);
        check("rdh_req", 32'(imemReq), 32'd1);

        // Jump keeps the upper region bits
        redirect(32'hF000_0000, 1'b1);
        fetch(32'h0800_0010, 32'hF000_0000, "jF");
        check("jump_hi_addr", imemAddr, 32'hF000_0040);

        // Redirect before the response: drain the stale word
        redirect(32'hC, 1'b1);
        check("at_c_addr", imemAddr, 32'hC);
        redirect(32'h103, 1'b0);
        check("drain_req", 32'(imemReq), 32'd0);
        check("drain_addr", imemAddr, 32'h100);
        tick();
        check("drain_req2", 32'(imemReq), 32'd0);
        imemValid = 1'b1;
        imemRdata = 32'h1234_5678;
        tick();
        imemValid = 1'b0;
        check("postdrain_req", 32'(imemReq), 32'd1);
        check("postdrain_valid", 32'(instrValid), 32'd0);
        check("postdrain_addr", imemAddr, 32'h100);
        fetch(32'h0000_0020, 32'h100, "f100");
        check("seq_addr", imemAddr, 32'h104);

        // PC+4 wraps to zero
        redirect(32'hFFFF_FFFC, 1'b1);
        fetch(32'h0000_0000, 32'hFFFF_FFFC, "wrap");
        check("wrap_addr", imemAddr, 32'h0);

        // Reset in the middle of HOLD
        redirect(32'h50, 1'b1);
        present(32'h2008_0005, 32'h50, 0, "hold50");
        reset = 1'b1;
        tick();
        check("rsthold_valid", 32'(instrValid), 32'd0);
        check("rsthold_req", 32'(imemReq), 32'd0);
        check("rsthold_addr", imemAddr, 32'h0);
        reset = 1'b0;
        tick();
        check("rsthold_resume", 32'(imemReq), 32'd1);

        // Reset in the middle of DRAIN
        redirect(32'h60, 1'b0);
        check("drain2_req", 32'(imemReq), 32'd0);
        reset = 1'b1;
        tick();
        check("rstdrain_valid", 32'(instrValid), 32'd0);
        check("rstdrain_req", 32'(imemReq), 32'd0);
        check("rstdrain_addr", imemAddr, 32'h0);
        reset = 1'b0;
        tick();
        check("rstdrain_resume", 32'(imemReq), 32'd1);
        fetch(32'h2008_0005, 32'h0, "final");
        check("final_addr", imemAddr, 32'h4);

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
